// File: rtl/dcache_wt_responder.sv
`timescale 1ns/1ps
// Data-side cache responder: direct-mapped, write-through, no-write-allocate.
// Loads hit out of register storage. Misses refill a whole line. Uncached
// loads read a single word. Every store is forwarded to the memory bus.
module dcache_wt_responder #(
   parameter int unsigned INDEX_W    = 8,
   parameter int unsigned TAG_W      = 20,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               data_valid,
   input  logic               data_op,
   input  logic [INDEX_W-1:0] data_index,
   input  logic [TAG_W-1:0]   data_tag,
   input  logic [3:0]         data_offset,
   input  logic [3:0]         data_wstrb,
   input  logic [31:0]        data_wdata,
   input  logic               isUncache,
   output logic               dcache_busy,
   output logic [31:0]        data_rdata,
   output logic               data_rdata_valid,
   output logic               rd_req,
   output logic               rd_type,
   output logic [31:0]        rd_addr,
   input  logic               rd_rdy,
   input  logic               ret_valid,
   input  logic               ret_last,
   input  logic [31:0]        ret_data,
   output logic               wr_req,
   output logic [31:0]        wr_addr,
   output logic [3:0]         wr_strb,
   output logic [31:0]        wr_data,
   input  logic               wr_rdy
);
   localparam int unsigned SETS   = 1 << INDEX_W;
   localparam int unsigned WSEL_W = $clog2(LINE_WORDS);

   typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, UC_READ, WRITE} state_t;

   state_t              state_q, state_d;
   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [WSEL_W-1:0]   req_wsel;
   logic                req_op;
   logic [3:0]          req_wstrb;
   logic [31:0]         req_wdata;
   logic                req_uc;
   logic [WSEL_W-1:0]   beat_cnt;
   logic [31:0]         cap_word;
   logic                uc_sent;

   logic [SETS-1:0]     valid_q;
   logic [TAG_W-1:0]    tag_q  [SETS];
   logic [31:0]         data_q [SETS][LINE_WORDS];

   logic                hit, load_hit, accept, store_hit;
   logic                refill_beat, refill_done, uc_done;
   logic [31:0]         line_addr, word_addr;
   logic                unused_offset_bits;

   // Loads always return a whole word, so the byte-within-word offset is dropped.
   assign unused_offset_bits = ^data_offset[1:0];

   assign line_addr   = {req_tag, req_index, 4'b0000};
   assign word_addr   = {req_tag, req_index, req_wsel, 2'b00};
   assign hit         = valid_q[req_index] && (tag_q[req_index] == req_tag) && !req_uc;
   assign load_hit    = (state_q == LOOKUP) && !req_op && hit;
   assign store_hit   = (state_q == LOOKUP) && req_op && hit;
   assign dcache_busy = (state_q != IDLE) && !load_hit;
   assign accept      = data_valid && !dcache_busy;
   assign refill_beat = (state_q == REFILL) && ret_valid;
   assign refill_done = refill_beat && ret_last;
   assign uc_done     = (state_q == UC_READ) && uc_sent && ret_valid && ret_last;

   // Next-state selection and all pipeline/bus outputs.
   always_comb begin
      state_d          = state_q;
      data_rdata       = '0;
      data_rdata_valid = 1'b0;
      rd_req           = 1'b0;
      rd_type          = 1'b0;
      rd_addr          = '0;
      wr_req           = 1'b0;
      wr_addr          = '0;
      wr_strb          = '0;
      wr_data          = '0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = LOOKUP;
         end
         LOOKUP: begin
            if (req_op) begin
               state_d = WRITE;
            end else if (req_uc) begin
               state_d = UC_READ;
            end else if (hit) begin
               data_rdata       = data_q[req_index][req_wsel];
               data_rdata_valid = 1'b1;
               state_d          = accept ? LOOKUP : IDLE;
            end else begin
               state_d = MISS;
            end
         end
         MISS: begin
            rd_req  = 1'b1;
            rd_type = 1'b1;
            rd_addr = line_addr;
            if (rd_rdy) state_d = REFILL;
         end
         REFILL: begin
            if (refill_done) begin
               // The requested word may arrive on the final beat itself.
               data_rdata       = (beat_cnt == req_wsel) ? ret_data : cap_word;
               data_rdata_valid = 1'b1;
               state_d          = IDLE;
            end
         end
         UC_READ: begin
            rd_req  = !uc_sent;
            rd_addr = word_addr;
            if (uc_done) begin
               data_rdata       = ret_data;
               data_rdata_valid = 1'b1;
               state_d          = IDLE;
            end
         end
         WRITE: begin
            wr_req  = 1'b1;
            wr_addr = word_addr;
            wr_strb = req_wstrb;
            wr_data = req_wdata;
            if (wr_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, request latch, refill beat tracking and uncached request phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         req_tag   <= '0;
         req_index <= '0;
         req_wsel  <= '0;
         req_op    <= 1'b0;
         req_wstrb <= '0;
         req_wdata <= '0;
         req_uc    <= 1'b0;
         beat_cnt  <= '0;
         cap_word  <= '0;
         uc_sent   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_tag   <= data_tag;
            req_index <= data_index;
            req_wsel  <= data_offset[2 +: WSEL_W];
            req_op    <= data_op;
            req_wstrb <= data_wstrb;
            req_wdata <= data_wdata;
            req_uc    <= isUncache;
         end
         if (refill_beat) begin
            beat_cnt <= refill_done ? '0 : beat_cnt + 1'b1;
            if (beat_cnt == req_wsel) cap_word <= ret_data;
         end
         if ((state_q == UC_READ) && !uc_sent && rd_rdy) uc_sent <= 1'b1;
         else if (uc_done)                                uc_sent <= 1'b0;
      end
   end

   // Line valid bits: cleared by reset, set when a refill completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            valid_q            <= '0;
      else if (refill_done) valid_q[req_index] <= 1'b1;
   end

   // Tag and data storage: refill beats, refill tag update and store-hit byte merge.
   always_ff @(posedge clk) begin
      if (refill_beat) data_q[req_index][beat_cnt] <= ret_data;
      if (refill_done) tag_q[req_index] <= req_tag;
      if (store_hit) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (req_wstrb[b]) data_q[req_index][req_wsel][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: doc/dcache_wt_responder.md
Name: dcache_wt_responder

Overview:
- Data-side cache responder that terminates the pipeline's data request interface: data_valid, data_op, data_index, data_tag, data_offset, data_wstrb, data_wdata, isUncache and dcache_busy.
- Direct-mapped, write-through, no-write-allocate: 256 sets × 16-byte lines.
- Load data goes back to the pipeline through data_rdata / data_rdata_valid.
- Misses, uncached accesses and all stores go to a simple read/write memory bus.

Parameters:
INDEX_W, 8, set index width (256 sets)
TAG_W, 20, physical tag width
LINE_WORDS, 4, 32-bit words per line (16 bytes)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
data_valid  input  1  request strobe
data_op  input  1  1=store, 0=load
data_index  input  8  set index
data_tag  input  20  physical tag (PFN)
data_offset  input  4  byte offset in line
data_wstrb  input  4  store byte enables
data_wdata  input  32  store data
isUncache  input  1  request is uncached
dcache_busy  output  1  responder cannot accept a request this cycle
data_rdata  output  32  load result
data_rdata_valid  output  1  one-cycle pulse qualifying data_rdata
rd_req  output  1  memory read request
rd_type  output  1  0=single word, 1=4-word line
rd_addr  output  32  read address
rd_rdy  input  1  memory accepts read request
ret_valid  input  1  read beat valid
ret_last  input  1  final read beat
ret_data  input  32  read beat data
wr_req  output  1  memory write request
wr_addr  output  32  write address (word aligned)
wr_strb  output  4  write byte enables
wr_data  output  32  write data
wr_rdy  input  1  memory accepts write

Behaviour:
- Request is accepted when data_valid=1 and dcache_busy=0. All request fields are latched on acceptance: tag, index, offset, op, wstrb, wdata, isUncache.
- Storage: valid[256], tag[256][20], data[256][4][32], all in registers. Reset clears every valid bit; tag and data contents are not reset.
- States: IDLE, LOOKUP, MISS, REFILL, UC_READ, WRITE.
- IDLE: accepts a request and moves to LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx]==latched tag && !uncached.
  - Cached load hit: data_rdata = data[idx][offset[3:2]], data_rdata_valid=1 this cycle, dcache_busy=0. A new request may be accepted in the same cycle (stay in LOOKUP), otherwise go to IDLE. Back-to-back hits sustain 1 per cycle.
  - Cached load miss: go to MISS.
  - Uncached load: go to UC_READ.
  - Any store: on a hit, merge data_wdata into the cached word by wstrb this cycle; on a miss the line is untouched. Then go to WRITE.
- dcache_busy = (state != IDLE) && !(state==LOOKUP && load hit). In IDLE it is 0. This is a combinational path from the tag compare.
- MISS: rd_req=1, rd_type=1, rd_addr={tag,index,4'b0}. Hold until rd_rdy=1, then go to REFILL.
- REFILL: beat counter 0..3 increments on ret_valid; each beat writes data[idx][cnt].
  - On the beat where cnt equals offset[3:2], capture the word for return.
  - On ret_valid && ret_last: set valid=1 and tag=latched tag; data_rdata = captured word (or ret_data if this beat is the requested one), data_rdata_valid=1; go to IDLE.
- UC_READ: rd_req=1, rd_type=0, rd_addr={tag,index,offset[3:2],2'b00} until rd_rdy.
  - Then wait for ret_valid && ret_last: data_rdata=ret_data, data_rdata_valid=1; go to IDLE.
  - Cache contents are not modified.
- WRITE: wr_req=1, wr_addr={tag,index,offset[3:2],2'b00}, wr_strb=latched wstrb, wr_data=latched wdata. Hold until wr_rdy=1, then go to IDLE. No write response is waited on.
- A store with wstrb=0 is still forwarded to memory with wr_strb=0.
- Requests are never cancelled; an accepted access always completes. Responses are returned strictly in acceptance order, since at most one miss or store is outstanding.
- Reset values: dcache_busy=0, data_rdata=0, data_rdata_valid=0, rd_req=0, rd_type=0, rd_addr=0, wr_req=0, wr_addr=0, wr_strb=0, wr_data=0, state=IDLE, beat counter=0.
- Reset asserted mid-refill or mid-write: the access is aborted immediately and requests drop the same cycle. The line being refilled stays invalid (valid bits are cleared anyway).
- ret_valid outside REFILL/UC_READ is ignored.

Test Plan:
- Reset, then cached load tag=0x00010, index=0x9e, offset=0x4 → rd_req with rd_type=1, rd_addr=0x000109e0. Return beats 0xA0,0xA1,0xA2,0xA3 (last=1) → data_rdata=0xA1 pulse; valid[0x9e]=1.
- Same load repeated, then offset=0xC on the next cycle → two consecutive data_rdata_valid pulses returning 0xA1, 0xA3; dcache_busy stays 0; no rd_req.
- Cached store hit at offset 0x8, wstrb=4'b0011, wdata=0xDEADBEEF → wr_req with wr_addr=0x000109e8, wr_strb=3, wr_data=0xDEADBEEF; busy until wr_rdy; a subsequent load at 0x8 returns 0x0000BEEF.
- Store miss to index 0x10 → wr_req only; a following load to index 0x10 misses (no allocate).
- Uncached load tag=0x1FAF0, index=0, offset=0 → rd_type=0, rd_addr=0x1FAF0000; ret 0x12345678 → data_rdata=0x12345678; a cached load to the same address still misses.
- Assert reset during REFILL after 2 beats → rd_req/busy drop; a repeat of the load misses again and issues a full refill.
